ex_trap_arbiter: RTL
====================

// Module: ex_trap_arbiter
// PURPOSE
//  Shares the single core external-trap handshake (core_ex_trap_valid/ready) between NSRC
//  interrupt sources. Per-source pending/enable/edge-mode state, priority select, one trap
//  in flight, claim/complete via a 4-word config bus. Sits in sparrow_soc between
//  peripherals (uart0/spi0/fpioa pins) and inst_core.
// PARAMETERS
//  NSRC   8                   number of interrupt sources, 1..31
//  IDW    $clog2(NSRC+1)      source-ID width; ID = index+1, ID 0 = none
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  rst          in   1     synchronous reset, active-high
//  src_irq      in   NSRC  raw source requests, already synchronous to clk
//  cfg_we       in   1     config write strobe
//  cfg_re       in   1     config read strobe
//  cfg_addr     in   4     byte offset; bits [3:2] decoded, [1:0] ignored
//  cfg_wdata    in   32    write data
//  cfg_rdata    out  32    read data, registered
//  trap_valid   out  1     to core_ex_trap_valid
//  trap_ready   in   1     from core_ex_trap_ready
//  trap_id      out  IDW   granted source ID, stable while trap_valid=1
// BEHAVIOUR
//  Reset: trap_valid=0, trap_id=0, cfg_rdata=0; ENABLE=0, EDGE=0, PENDING=0; FSM=IDLE.
//  Registers:
//    0x0 ENABLE[NSRC-1:0] rw.
//    0x4 EDGE rw; 1=rising-edge source, 0=level.
//    0x8 PENDING: read; write-1-clears edge bits only.
//    0xC CLAIM: read returns in-flight ID (0 if none); write ID = complete.
//  Pending:
//    edge: set on src_irq 0->1 (src_q register); cleared by W1C or by grant.
//    level: PENDING[i] = registered src_irq[i]; never cleared by grant.
//  Set wins over a same-cycle W1C/grant clear. Unused cfg_wdata bits ignored.
//  Eligible[i] = PENDING[i] & ENABLE[i] & (ID i+1 not in flight).
//  FSM:
//    IDLE->REQ when any eligible: latch winner into trap_id, trap_valid=1 next cycle.
//    REQ: hold trap_valid/trap_id until trap_ready sampled 1, even if source drops or is
//      disabled. On valid&ready: clear winner's edge pending, drop trap_valid, go CLAIMED.
//    CLAIMED: trap_valid=0; wait for a CLAIM write with data==trap_id -> IDLE, trap_id=0.
//      A mismatched complete ID is ignored.
//    Earliest re-request is the cycle after the complete write.
//  Latency:
//    edge src rising (cycle 0) -> PENDING cycle 1 -> trap_valid cycle 2.
//    level src: same timing.
//  Reads: cfg_rdata updated the cycle after cfg_re; holds its value otherwise.
//  Simultaneous cfg_we & cfg_re to the same address: read returns the pre-write value.
//  Reset mid-operation: all state and outputs return to reset values immediately; an
//    in-flight trap is abandoned.
// CONFIGURATION
//  EX_TRAP_RR_EN defined: round-robin; search starts at the index after the last granted
//    source, wrapping NSRC-1 -> 0. Last-grant pointer resets to NSRC-1 (first search
//    starts at 0).
//  Undefined: fixed priority, lowest index wins; no pointer register.
// STRUCTURE
//  Shared package sparrow_trap_pkg: register offsets (TRAP_ENABLE=4'h0, TRAP_EDGE=4'h4,
//    TRAP_PENDING=4'h8, TRAP_CLAIM=4'hC), FSM enum trap_st_e {IDLE, REQ, CLAIMED}.
//  Sub-module trap_pick: combinational winner select from eligible vector plus pointer;
//    fixed or round-robin per EX_TRAP_RR_EN; outputs hit and index.
// TESTING
//  1 Level: ENABLE=0x01, EDGE=0, src_irq[0]=1 -> trap_valid=1, trap_id=1 two cycles later.
//    Ready -> CLAIMED; CLAIM read = 1; write 1 -> IDLE.
//  2 Edge: EDGE=0x04, ENABLE=0x04, 1-cycle pulse on src_irq[2] -> PENDING=0x04,
//    trap_id=3; PENDING=0x00 after the handshake.
//  3 Priority: src 1 and 5 pending together.
//    Fixed: grants ID 2 then 6.
//    RR_EN: after ID 2, src 1 re-raised -> ID 6 before ID 2.
//  4 ready held 0 for 10 cycles, source deasserted -> trap_valid, trap_id=1 held stable.
//  5 Complete with wrong ID (write 4 while claimed 1) -> stays CLAIMED. Edge pulse +
//    same-cycle W1C on that bit -> PENDING bit stays 1.
//  6 rst asserted in REQ -> next cycle trap_valid=0, trap_id=0, ENABLE=0, PENDING=0.

Source files
------------

// File: rtl/sparrow_trap_pkg.sv
// Shared definitions for the external-trap arbiter: config register offsets and FSM states.
package sparrow_trap_pkg;

   localparam logic [3:0] TRAP_ENABLE  = 4'h0;
   localparam logic [3:0] TRAP_EDGE    = 4'h4;
   localparam logic [3:0] TRAP_PENDING = 4'h8;
   localparam logic [3:0] TRAP_CLAIM   = 4'hC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CLAIMED = 2'd2
   } trap_st_e;

endpackage

// File: rtl/trap_pick.sv
// Combinational winner select over the eligible vector.
// EX_TRAP_RR_EN: round-robin starting after last_i; otherwise lowest index wins.
module trap_pick #(
   parameter int unsigned NSRC = 8,
   parameter int unsigned IDW  = $clog2(NSRC + 1)
) (
   input  logic [NSRC-1:0] elig_i,
`ifdef EX_TRAP_RR_EN
   input  logic [IDW-1:0]  last_i,
`endif
   output logic            hit_o,
   output logic [IDW-1:0]  idx_o
);

`ifdef EX_TRAP_RR_EN
   always_comb begin
      int unsigned j;
      hit_o = 1'b0;
      idx_o = '0;
      j     = 0;
      // Scan NSRC slots beginning one past the last grant; first hit wins.
      for (int unsigned k = 0; k < NSRC; k++) begin
         j = (32'(last_i) + 32'd1 + k) % NSRC;
         if (!hit_o && elig_i[j]) begin
            hit_o = 1'b1;
            idx_o = IDW'(j);
         end
      end
   end
`else
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (elig_i[i]) begin
            hit_o = 1'b1;
            idx_o = IDW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/ex_trap_arbiter.sv
// Shares the core external-trap handshake between NSRC sources with claim/complete.
// EX_TRAP_RR_EN selects round-robin arbitration instead of fixed priority.
module ex_trap_arbiter
   import sparrow_trap_pkg::*;
#(
   parameter int unsigned NSRC = 8,
   parameter int unsigned IDW  = $clog2(NSRC + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NSRC-1:0] src_irq_i,
   input  logic            cfg_we_i,
   input  logic            cfg_re_i,
   input  logic [3:0]      cfg_addr_i,
   input  logic [31:0]     cfg_wdata_i,
   output logic [31:0]     cfg_rdata_o,
   output logic            trap_valid_o,
   input  logic            trap_ready_i,
   output logic [IDW-1:0]  trap_id_o
);

   logic [NSRC-1:0] enable_q, edge_q, src_q, epend_q, epend_d;
   logic [NSRC-1:0] pending, inflight_mask, eligible, w1c, grant_clr;
   logic [3:0]      addr_w;
   logic            wr_en, wr_edge, wr_pend, wr_claim;
   logic            pick_hit;
   logic [IDW-1:0]  pick_idx;
   trap_st_e        state_q, state_d;
   logic            trap_valid_q, trap_valid_d;
   logic [IDW-1:0]  trap_id_q, trap_id_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            unused_bits;
`ifdef EX_TRAP_RR_EN
   logic [IDW-1:0]  last_q, last_d;
`endif

   assign unused_bits = ^{cfg_addr_i[1:0], cfg_wdata_i[31:NSRC]};

   assign addr_w   = {cfg_addr_i[3:2], 2'b00};
   assign wr_en    = cfg_we_i && (addr_w == TRAP_ENABLE);
   assign wr_edge  = cfg_we_i && (addr_w == TRAP_EDGE);
   assign wr_pend  = cfg_we_i && (addr_w == TRAP_PENDING);
   assign wr_claim = cfg_we_i && (addr_w == TRAP_CLAIM);

   always_comb begin
      inflight_mask = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         inflight_mask[i] = (trap_id_q == IDW'(i + 1));
      end
   end

   // Level sources mirror src_q; edge sources use the sticky epend_q bit.
   assign pending   = (edge_q & epend_q) | (~edge_q & src_q);
   assign eligible  = pending & enable_q & ~inflight_mask;
   assign w1c       = wr_pend ? cfg_wdata_i[NSRC-1:0] : '0;
   assign grant_clr = ((state_q == REQ) && trap_ready_i) ? inflight_mask : '0;
   assign epend_d   = (epend_q & ~(w1c | grant_clr)) | (src_irq_i & ~src_q & edge_q);

   trap_pick #(.NSRC(NSRC), .IDW(IDW)) u_pick (
      .elig_i (eligible),
`ifdef EX_TRAP_RR_EN
      .last_i (last_q),
`endif
      .hit_o  (pick_hit),
      .idx_o  (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      trap_valid_d = trap_valid_q;
      trap_id_d    = trap_id_q;
`ifdef EX_TRAP_RR_EN
      last_d       = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               state_d      = REQ;
               trap_valid_d = 1'b1;
               trap_id_d    = pick_idx + IDW'(1);
`ifdef EX_TRAP_RR_EN
               last_d       = pick_idx;
`endif
            end
         end
         REQ: begin
            if (trap_ready_i) begin
               state_d      = CLAIMED;
               trap_valid_d = 1'b0;
            end
         end
         CLAIMED: begin
            if (wr_claim && (cfg_wdata_i[IDW-1:0] == trap_id_q)) begin
               state_d   = IDLE;
               trap_id_d = '0;
            end
         end
         default: begin
            state_d      = IDLE;
            trap_valid_d = 1'b0;
            trap_id_d    = '0;
         end
      endcase
   end

   // Reads sample pre-write state, so a same-cycle write is not visible yet.
   always_comb begin
      rdata_d = rdata_q;
      if (cfg_re_i) begin
         case (addr_w)
            TRAP_ENABLE:  rdata_d = 32'(enable_q);
            TRAP_EDGE:    rdata_d = 32'(edge_q);
            TRAP_PENDING: rdata_d = 32'(pending);
            TRAP_CLAIM:   rdata_d = 32'(trap_id_q);
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enable_q     <= '0;
         edge_q       <= '0;
         src_q        <= '0;
         epend_q      <= '0;
         state_q      <= IDLE;
         trap_valid_q <= 1'b0;
         trap_id_q    <= '0;
         rdata_q      <= '0;
`ifdef EX_TRAP_RR_EN
         last_q       <= IDW'(NSRC - 1);
`endif
      end else begin
         if (wr_en)   enable_q <= cfg_wdata_i[NSRC-1:0];
         if (wr_edge) edge_q   <= cfg_wdata_i[NSRC-1:0];
         src_q        <= src_irq_i;
         epend_q      <= epend_d;
         state_q      <= state_d;
         trap_valid_q <= trap_valid_d;
         trap_id_q    <= trap_id_d;
         rdata_q      <= rdata_d;
`ifdef EX_TRAP_RR_EN
         last_q       <= last_d;
`endif
      end
   end

   assign cfg_rdata_o  = rdata_q;
   assign trap_valid_o = trap_valid_q;
   assign trap_id_o    = trap_id_q;

endmodule
